sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO. Next generation of the team's 32x8 buffer.
- Generalises data width and depth.
- Adds programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags with clear, a read-valid strobe, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer logic in one clock domain.

Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- AF_LEVEL, 28, almost_full asserts when occupancy >= AF_LEVEL (1..DEPTH-1)
- AE_LEVEL, 4, almost_empty asserts when occupancy <= AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = registered read (standard); 1 = first-word-fall-through

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- wr_en  input  1  write request
- rd_en  input  1  read request
- clr_err  input  1  synchronous clear of overflow/underflow
- data_in  input  DATA_W  write data
- data_out  output  DATA_W  read data
- data_valid  output  1  data_out holds a newly read/available word
- buf_empty  output  1  occupancy == 0
- buf_full  output  1  occupancy == DEPTH
- almost_empty  output  1  occupancy <= AE_LEVEL
- almost_full  output  1  occupancy >= AF_LEVEL
- counter  output  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

Behaviour:
- One clock (clk); reset asynchronous and active-high (rst). All state is clocked on the rising edge of clk.
- Reset clears wr_ptr, rd_ptr, counter, data_out, data_valid, overflow and underflow to 0. Flags after reset: buf_empty=1, buf_full=0, almost_empty=1, almost_full=0.
- Memory contents are not reset.
- Accepted write: wr_en && !buf_full. Stores data_in at wr_ptr; wr_ptr increments modulo DEPTH.
- Accepted read: rd_en && !buf_empty. rd_ptr increments modulo DEPTH.
- Flags are evaluated from the registered counter before the edge. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- Counter update per cycle:
  - +1 on write only
  - -1 on read only
  - unchanged when both are accepted or neither is
  - never exceeds DEPTH and never goes below 0
- All status flags are combinational decodes of counter and change in the cycle after the edge that updates counter.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0. Full/empty come from counter, never from pointer comparison.
- FWFT=0 (standard mode):
  - An accepted read loads mem[rd_ptr] into data_out at that edge: 1-cycle latency.
  - data_valid is high for exactly the cycle after each accepted read, else 0.
  - data_out holds its last value otherwise.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally whenever !buf_empty; 0 when empty.
  - data_valid = !buf_empty.
  - rd_en acts as an acknowledge that pops the displayed word.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- overflow sets on the edge where wr_en && buf_full. underflow sets on the edge where rd_en && buf_empty.
- Both error flags hold until clr_err. If a set condition and clr_err occur in the same cycle, set wins.
- Rejected operations change no pointer, counter or memory location.
- Reset asserted mid-operation immediately (asynchronously) returns the block to the reset state. Any in-flight data is discarded.

Test Plan:
- Reset, then write 0x01..0x20 (32 words) with DATA_W=8, ADDR_W=5 -> counter steps 1..32. almost_full rises when counter=28. buf_full=1 at 32. almost_empty falls when counter=5.
- From full, read 32 times (FWFT=0) -> data_out = 0x01..0x20, each one cycle after its rd_en, with data_valid high one cycle per read. buf_empty=1 at end and almost_empty=1 from counter<=4.
- Fill to 16, then hold wr_en=rd_en=1 for 40 cycles -> counter stays 16. Pointers wrap past 31 to 0. Read-back order matches write order with no loss.
- Full FIFO, wr_en=1 with data 0xAA -> write rejected, overflow=1, counter=32. Pulse clr_err -> overflow=0. Empty FIFO with rd_en=1 -> underflow=1 and data_out unchanged.
- FWFT=1: write 0x5A into empty -> next cycle data_out=0x5A, data_valid=1. Pulse rd_en -> buf_empty=1, data_valid=0.
- Write 10 words, assert rst asynchronously between clock edges -> outputs return to reset values immediately. Subsequent write/read of 0x3C returns 0x3C.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with thresholds, sticky errors and optional FWFT read
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              buf_empty,
    output logic              buf_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   counter,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C   = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C   = (ADDR_W + 1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              wr_acc, rd_acc;

    // Status flags decode the registered occupancy; full/empty never look at pointers
    assign buf_empty    = count_q == '0;
    assign buf_full     = count_q == FULL_C;
    assign almost_empty = count_q <= AE_C;
    assign almost_full  = count_q >= AF_C;
    assign counter      = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign wr_acc       = wr_en && !buf_full;
    assign rd_acc       = rd_en && !buf_empty;

    // In FWFT mode the head word is shown directly; otherwise the registered read result
    assign data_out   = (FWFT != 0) ? (buf_empty ? '0 : mem_q[rd_ptr_q]) : dout_q;
    assign data_valid = (FWFT != 0) ? !buf_empty : valid_q;

    // Next-state: occupancy, pointers, read register and sticky errors (set beats clear)
    always_comb begin
        count_d  = (wr_acc && !rd_acc) ? count_q + 1'b1 :
                   (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        dout_d   = rd_acc ? mem_q[rd_ptr_q] : dout_q;
        valid_d  = rd_acc;
        ovf_d    = (wr_en && buf_full) || (ovf_q && !clr_err);
        udf_d    = (rd_en && buf_empty) || (udf_q && !clr_err);
    end

    // Storage array is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end
endmodule
